// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file and decode:
// default widths and the architectural register index names.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    V0 = 3'd0,
    V1 = 3'd1,
    V2 = 3'd2,
    V3 = 3'd3,
    T0 = 3'd4,
    T1 = 3'd5,
    A0 = 3'd6,
    A1 = 3'd7
  } regIdx_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave):
// two read ports, one write port, the reservation handshake and the busy count.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] readAddr1;
  logic [ADDR_W-1:0] readAddr2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              readBusy1;
  logic              readBusy2;
  logic              writeEn;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;
  logic              reserveEn;
  logic [ADDR_W-1:0] reserveAddr;
  logic              reserveOk;
  logic [ADDR_W:0]   busyCount;

  modport master (
    output readAddr1, readAddr2, writeEn, writeAddr, writeData, reserveEn, reserveAddr,
    input  readData1, readData2, readBusy1, readBusy2, reserveOk, busyCount
  );

  modport slave (
    input  readAddr1, readAddr2, writeEn, writeAddr, writeData, reserveEn, reserveAddr,
    output readData1, readData2, readBusy1, readBusy2, reserveOk, busyCount
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: reservation handshake, per-register pending bits
// and the registered count of pending registers.
module regfile_scoreboard #(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       writeEn,
  input  logic [ADDR_W-1:0]          writeAddr,
  input  logic                       reserveEn,
  input  logic [ADDR_W-1:0]          reserveAddr,
  output logic                       reserveOk,
  output logic [(2**ADDR_W)-1:0]     pending,
  output logic [ADDR_W:0]            busyCount
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pendingNext_s;
  logic [ADDR_W:0]     busyCount_r;
  logic [ADDR_W:0]     busyNext_s;
  logic                reserveOk_s;
  logic                reserveZero_s;
  logic                writeZero_s;

  function automatic logic [ADDR_W:0] countOnes(input logic [NUM_REGS-1:0] bits);
    logic [ADDR_W:0] total;
    total = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      total = total + {{ADDR_W{1'b0}}, bits[i]};
    end
    return total;
  endfunction

  // Handshake and next pending state; a same-address reservation beats the write's clear.
  always_comb begin
    reserveZero_s = 1'b0;
    writeZero_s   = 1'b0;
    if (ZERO_REG != 0) begin
      reserveZero_s = (reserveAddr == {ADDR_W{1'b0}});
      writeZero_s   = (writeAddr == {ADDR_W{1'b0}});
    end else begin
      reserveZero_s = 1'b0;
      writeZero_s   = 1'b0;
    end
    reserveOk_s = reserveEn & (reserveZero_s | ~pending_r[reserveAddr] |
                               (writeEn & (writeAddr == reserveAddr)));
    pendingNext_s = pending_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reserveOk_s && !reserveZero_s && (reserveAddr == ADDR_W'(i))) begin
        pendingNext_s[i] = 1'b1;
      end else if (writeEn && !writeZero_s && (writeAddr == ADDR_W'(i))) begin
        pendingNext_s[i] = 1'b0;
      end else begin
        pendingNext_s[i] = pending_r[i];
      end
    end
    busyNext_s = countOnes(pendingNext_s);
  end

  // Pending bits and busy count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r   <= {NUM_REGS{1'b0}};
      busyCount_r <= {(ADDR_W+1){1'b0}};
    end else begin
      pending_r   <= pendingNext_s;
      busyCount_r <= busyNext_s;
    end
  end

  assign reserveOk = reserveOk_s;
  assign pending   = pending_r;
  assign busyCount = busyCount_r;

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file: data array, read muxes and scoreboard.
// Optional REGFILE_BYPASS_EN forwards the write port to the read ports in the same cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] pending_s;
  logic                writeZero_s;
  logic                readZero1_s;
  logic                readZero2_s;
  logic [DATA_W-1:0]   readData1_s;
  logic [DATA_W-1:0]   readData2_s;
  logic                readBusy1_s;
  logic                readBusy2_s;

  assign writeZero_s = (ZERO_REG != 0) && (bus.writeAddr == {ADDR_W{1'b0}});
  assign readZero1_s = (ZERO_REG != 0) && (bus.readAddr1 == {ADDR_W{1'b0}});
  assign readZero2_s = (ZERO_REG != 0) && (bus.readAddr2 == {ADDR_W{1'b0}});

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) scoreboard (
    .clk         (clk),
    .reset       (reset),
    .writeEn     (bus.writeEn),
    .writeAddr   (bus.writeAddr),
    .reserveEn   (bus.reserveEn),
    .reserveAddr (bus.reserveAddr),
    .reserveOk   (bus.reserveOk),
    .pending     (pending_s),
    .busyCount   (bus.busyCount)
  );

  // Data array; writes to a hardwired zero register are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.writeEn && !writeZero_s) begin
      regs_r[bus.writeAddr] <= bus.writeData;
    end
  end

  // Read muxes: zero register first, then optional forwarding, then stored state.
  always_comb begin
    readData1_s = {DATA_W{1'b0}};
    readBusy1_s = 1'b0;
    readData2_s = {DATA_W{1'b0}};
    readBusy2_s = 1'b0;
    if (readZero1_s) begin
      readData1_s = {DATA_W{1'b0}};
      readBusy1_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.writeEn && !writeZero_s && (bus.writeAddr == bus.readAddr1)) begin
      readData1_s = bus.writeData;
      readBusy1_s = 1'b0;
`endif
    end else begin
      readData1_s = regs_r[bus.readAddr1];
      readBusy1_s = pending_s[bus.readAddr1];
    end
    if (readZero2_s) begin
      readData2_s = {DATA_W{1'b0}};
      readBusy2_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (bus.writeEn && !writeZero_s && (bus.writeAddr == bus.readAddr2)) begin
      readData2_s = bus.writeData;
      readBusy2_s = 1'b0;
`endif
    end else begin
      readData2_s = regs_r[bus.readAddr2];
      readBusy2_s = pending_s[bus.readAddr2];
    end
  end

  assign bus.readData1 = readData1_s;
  assign bus.readData2 = readData2_s;
  assign bus.readBusy1 = readBusy1_s;
  assign bus.readBusy2 = readBusy2_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance without and one with a hardwired zero register,
// driven identically and compared against an array-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) busA ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) busB ();

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dutA (.clk(clk), .reset(reset), .bus(busA));
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dutB (.clk(clk), .reset(reset), .bus(busB));

  logic [2:0]  rA1 = 3'd0, rA2 = 3'd0, wA = 3'd0, resA = 3'd0;
  logic        wEn = 1'b0, resEn = 1'b0;
  logic [15:0] wD = 16'h0000;

  assign busA.readAddr1 = rA1;  assign busB.readAddr1 = rA1;
  assign busA.readAddr2 = rA2;  assign busB.readAddr2 = rA2;
  assign busA.writeEn = wEn;    assign busB.writeEn = wEn;
  assign busA.writeAddr = wA;   assign busB.writeAddr = wA;
  assign busA.writeData = wD;   assign busB.writeData = wD;
  assign busA.reserveEn = resEn;  assign busB.reserveEn = resEn;
  assign busA.reserveAddr = resA; assign busB.reserveAddr = resA;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: [0] = plain file, [1] = file with hardwired zero register.
  logic [15:0] mMem [2][8];
  logic        mPend [2][8];
  int          mCnt [2];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic isZ(input int z, input logic [2:0] a);
    return (z == 1) && (a == 3'd0);
  endfunction

  function automatic logic [15:0] expData(input int z, input logic [2:0] a);
    if (isZ(z, a)) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (wEn && !isZ(z, wA) && wA == a) return wD;
`endif
    return mMem[z][a];
  endfunction

  function automatic logic expBusy(input int z, input logic [2:0] a);
    if (isZ(z, a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wEn && !isZ(z, wA) && wA == a) return 1'b0;
`endif
    return mPend[z][a];
  endfunction

  function automatic logic expOk(input int z);
    return resEn && (isZ(z, resA) || !mPend[z][resA] || (wEn && wA == resA));
  endfunction

  task automatic modelReset();
    for (int z = 0; z < 2; z++) begin
      mCnt[z] = 0;
      for (int i = 0; i < 8; i++) begin
        mMem[z][i] = 16'h0000;
        mPend[z][i] = 1'b0;
      end
    end
  endtask

  task automatic modelClock();
    for (int z = 0; z < 2; z++) begin
      logic ok, wClr, rSet, rNew, same;
      ok   = expOk(z);
      wClr = wEn && !isZ(z, wA) && mPend[z][wA];
      rSet = ok && !isZ(z, resA);
      rNew = rSet && !mPend[z][resA];
      same = rSet && wEn && (wA == resA);
      if (wClr && !same) mCnt[z] = mCnt[z] - 1;
      if (rNew) mCnt[z] = mCnt[z] + 1;
      if (wEn && !isZ(z, wA)) begin
        mMem[z][wA] = wD;
        mPend[z][wA] = 1'b0;
      end
      if (rSet) mPend[z][resA] = 1'b1;
    end
  endtask

  task automatic checkComb(input string tag);
    for (int z = 0; z < 2; z++) begin
      string n;
      n = $sformatf("%s/%s", tag, (z == 0) ? "plain" : "zreg");
      checkVal({n, " rd1"}, (z == 0) ? busA.readData1 : busB.readData1, expData(z, rA1));
      checkVal({n, " rd2"}, (z == 0) ? busA.readData2 : busB.readData2, expData(z, rA2));
      checkVal({n, " busy1"}, (z == 0) ? busA.readBusy1 : busB.readBusy1, expBusy(z, rA1));
      checkVal({n, " busy2"}, (z == 0) ? busA.readBusy2 : busB.readBusy2, expBusy(z, rA2));
      checkVal({n, " resOk"}, (z == 0) ? busA.reserveOk : busB.reserveOk, expOk(z));
    end
  endtask

  task automatic checkCount(input string tag);
    checkVal({tag, "/plain cnt"}, busA.busyCount, mCnt[0]);
    checkVal({tag, "/zreg cnt"}, busB.busyCount, mCnt[1]);
  endtask

  task automatic combPhase(input string tag);
    @(negedge clk);
    checkComb(tag);
  endtask

  task automatic edgePhase(input string tag);
    @(posedge clk);
    modelClock();
    #1;
    checkCount(tag);
  endtask

  task automatic step(input string tag);
    combPhase(tag);
    edgePhase(tag);
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra, input logic [2:0] r1, input logic [2:0] r2);
    wEn = we; wA = wa; wD = wd; resEn = re; resA = ra; rA1 = r1; rA2 = r2;
  endtask

  initial begin
    modelReset();
    // Reset held with activity on the bus: nothing may change.
    drive(1'b0, 3'd2, 16'h7777, 1'b1, 3'd2, 3'd2, 3'd5);
    #1;
    checkComb("rst");
    checkCount("rst");
    wEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wEn = 1'b0;
    checkComb("rstHold");
    checkCount("rstHold");
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Write then read on both ports.
    drive(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd1, 3'd2);
    step("wrBeef");
    drive(1'b1, V0, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd5);
    combPhase("rdBeef");
    checkVal("beefPort1", busA.readData1, 32'h0000BEEF);
    checkVal("beefPort2", busA.readData2, 32'h0000BEEF);
    edgePhase("wrZero");
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, V0, 3'd5);
    combPhase("rdZero");
    checkVal("zeroRegRead", busB.readData1, 32'h00000000);
    checkVal("plainReg0Read", busA.readData1, 32'h00001234);
    edgePhase("rdZero");

    // Reservation conflict on register 3.
    drive(1'b0, 3'd0, 16'h0000, 1'b1, V3, V3, 3'd0);
    combPhase("res3");
    checkVal("res3Ok", busA.reserveOk, 32'd1);
    edgePhase("res3");
    combPhase("res3Again");
    checkVal("res3Busy", busA.readBusy1, 32'd1);
    checkVal("res3Cnt", busA.busyCount, 32'd1);
    checkVal("res3Retry", busA.reserveOk, 32'd0);
    edgePhase("res3Again");
    drive(1'b1, V3, 16'h5555, 1'b1, V3, V3, 3'd0);
    combPhase("wrRes3");
    checkVal("wrRes3Ok", busA.reserveOk, 32'd1);
    edgePhase("wrRes3");
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, V3, 3'd0);
    combPhase("after3");
    checkVal("after3Busy", busA.readBusy1, 32'd1);
    checkVal("after3Data", busA.readData1, 32'h00005555);
    checkVal("after3Cnt", busA.busyCount, 32'd1);
    edgePhase("after3");

    // Counter: reserve one register while clearing another.
    drive(1'b0, 3'd0, 16'h0000, 1'b1, V2, V2, V1);
    step("res2");
    drive(1'b1, V2, 16'h2222, 1'b1, V1, V2, V1);
    step("res1wr2");
    checkVal("netZeroCnt", busA.busyCount, 32'd2);
    drive(1'b1, V1, 16'h1111, 1'b0, 3'd0, V1, V3);
    step("clr1");
    drive(1'b1, V3, 16'h3333, 1'b0, 3'd0, V1, V3);
    step("clr3");
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 3'(i), 3'(7 - i));
      step("resAll");
    end
    checkVal("fullCntPlain", busA.busyCount, 32'd8);
    checkVal("fullCntZreg", busB.busyCount, 32'd7);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 3'd0, 3'(i), 3'(i + 1));
      step("wrAll");
    end
    checkVal("emptyCnt", busA.busyCount, 32'd0);

    // Forwarding on a pending register.
    drive(1'b0, 3'd0, 16'h0000, 1'b1, T0, T0, 3'd0);
    step("res4");
    drive(1'b1, T0, 16'h00AA, 1'b0, 3'd0, T0, 3'd0);
    combPhase("byp4");
`ifdef REGFILE_BYPASS_EN
    checkVal("bypData", busA.readData1, 32'h000000AA);
    checkVal("bypBusy", busA.readBusy1, 32'd0);
`else
    checkVal("oldData", busA.readData1, 32'h00001004);
    checkVal("oldBusy", busA.readBusy1, 32'd1);
`endif
    edgePhase("byp4");

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 1) != 0), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (n == 200) begin
        #2;
        wEn = 1'b0;
        reset = 1'b0;
        #1;
        modelReset();
        checkComb("midRst");
        checkCount("midRst");
        wEn = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkCount("postRst");
      end else begin
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
